// File: rtl/viol_monitor_if.sv
// Notifier inputs, clear, and the 4-phase read/status bundle for viol_monitor.
// The bench drives through master; the monitor consumes through slave.
interface viol_monitor_if #(
  parameter int N_SRC = 8,
  parameter int CNT_W = 8,
  parameter int SEL_W = 3
);
  logic [N_SRC-1:0] NR;
  logic             CLR;
  logic             RD_REQ;
  logic [SEL_W-1:0] RD_SEL;
  logic             RD_ACK;
  logic [CNT_W-1:0] RD_DATA;
  logic             FLAG;
  logic [SEL_W-1:0] FIRST;
  logic             FIRST_VLD;

  modport master (
    output NR, CLR, RD_REQ, RD_SEL,
    input  RD_ACK, RD_DATA, FLAG, FIRST, FIRST_VLD
  );

  modport slave (
    input  NR, CLR, RD_REQ, RD_SEL,
    output RD_ACK, RD_DATA, FLAG, FIRST, FIRST_VLD
  );
endinterface

// File: rtl/viol_monitor.sv
// Timing-violation notifier monitor: per-source toggle sync/detect and saturating
// counters, sticky FLAG / first-source capture, and a 4-phase register read port.

// One notifier source: 3-flop sync, toggle detect, saturating counter.
module viol_lane #(
  parameter int CNT_W = 8
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             nr,
  input  logic             base_ld,
  input  logic             clr,
  output logic             ev,
  output logic [CNT_W-1:0] cnt
);
  // sync_q[0]=s1, [1]=s2, [2]=s3
  logic [2:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // Baseline load fills the whole chain so the first sample never looks like a toggle.
    sync_d = base_ld ? {3{nr}} : {sync_q[1:0], nr};
    ev     = sync_q[1] ^ sync_q[2];
    cnt_d  = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (ev && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      sync_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cnt = cnt_q;
endmodule

module viol_monitor #(
  parameter int N_SRC = 8,
  parameter int CNT_W = 8,
  parameter int SEL_W = 3
) (
  input  logic          CK,
  input  logic          RN,
  viol_monitor_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACK = 2'd1, WAIT = 2'd2} rd_state_e;

  typedef struct packed {
    logic             ack;
    logic [CNT_W-1:0] data;
  } rd_rsp_t;

  logic                        base_q, base_d;
  logic [N_SRC-1:0]            ev;
  logic [N_SRC-1:0][CNT_W-1:0] cnt;

  logic                        flag_q, flag_d;
  logic [SEL_W-1:0]            first_q, first_d;
  logic                        first_vld_q, first_vld_d;
  logic [SEL_W-1:0]            first_idx;

  rd_state_e                   state_q, state_d;
  rd_rsp_t                     rsp_q, rsp_d;
  logic [CNT_W-1:0]            rd_mux;

  generate
    for (genvar g = 0; g < N_SRC; g++) begin : g_lane
      viol_lane #(.CNT_W(CNT_W)) u_lane (
        .CK      (CK),
        .RN      (RN),
        .nr      (bus.NR[g]),
        .base_ld (!base_q),
        .clr     (bus.CLR),
        .ev      (ev[g]),
        .cnt     (cnt[g])
      );
    end
  endgenerate

  always_comb begin : c_evt
    base_d    = 1'b1;
    first_idx = '0;
    // Descending scan leaves the lowest firing index.
    for (int i = N_SRC - 1; i >= 0; i--)
      if (ev[i]) first_idx = SEL_W'(i);

    flag_d      = flag_q;
    first_d     = first_q;
    first_vld_d = first_vld_q;
    if (bus.CLR) begin
      flag_d      = 1'b0;
      first_d     = '0;
      first_vld_d = 1'b0;
    end else if (|ev) begin
      flag_d = 1'b1;
      if (!first_vld_q) begin
        first_d     = first_idx;
        first_vld_d = 1'b1;
      end
    end
  end

  always_comb begin : c_rd
    // Out-of-range selects match no lane and read as zero.
    rd_mux = '0;
    for (int i = 0; i < N_SRC; i++)
      if (bus.RD_SEL == SEL_W'(i)) rd_mux = cnt[i];

    state_d = state_q;
    rsp_d   = rsp_q;
    case (state_q)
      IDLE: if (bus.RD_REQ) begin
        state_d = ACK;
        rsp_d   = '{ack: 1'b1, data: rd_mux};
      end
      ACK: if (!bus.RD_REQ) begin
        state_d = IDLE;
        rsp_d   = '0;
      end
      default: begin
        state_d = IDLE;
        rsp_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      base_q      <= 1'b0;
      flag_q      <= 1'b0;
      first_q     <= '0;
      first_vld_q <= 1'b0;
      state_q     <= IDLE;
      rsp_q       <= '0;
    end else begin
      base_q      <= base_d;
      flag_q      <= flag_d;
      first_q     <= first_d;
      first_vld_q <= first_vld_d;
      state_q     <= state_d;
      rsp_q       <= rsp_d;
    end
  end

  assign bus.RD_ACK    = rsp_q.ack;
  assign bus.RD_DATA   = rsp_q.data;
  assign bus.FLAG      = flag_q;
  assign bus.FIRST     = first_q;
  assign bus.FIRST_VLD = first_vld_q;
endmodule

// File: tb/tb_viol_monitor.sv
// Scoreboarded bench for viol_monitor: reads push expected counts from a toggle
// model; a negedge monitor pops and compares on each RD_ACK rise.
module tb_viol_monitor;
  localparam int N  = 8;
  localparam int CW = 8;
  localparam int SW = 4;

  logic CK = 1'b0;
  logic RN;

  viol_monitor_if #(.N_SRC(N), .CNT_W(CW), .SEL_W(SW)) bus ();

  viol_monitor #(.N_SRC(N), .CNT_W(CW), .SEL_W(SW)) dut (
    .CK  (CK),
    .RN  (RN),
    .bus (bus)
  );

  always #5 CK = ~CK;

  typedef struct {
    int          sel;
    logic [CW-1:0] data;
  } exp_t;

  int            total = 0;
  int            bad   = 0;
  logic [CW-1:0] exp_cnt [N];
  logic          exp_flag;
  logic          exp_vld;
  logic [SW-1:0] exp_first;
  exp_t          sb [$];
  logic          ack_prev = 1'b0;

  // Scoreboard consumer: one compare per read, at the cycle RD_ACK rises.
  always @(negedge CK) begin
    if (bus.RD_ACK === 1'b1 && ack_prev !== 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ack: got RD_ACK=1 data=%0d, expected no read pending", bus.RD_DATA);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.RD_DATA !== e.data) begin
          bad++;
          $display("FAIL read_data sel=%0d: got %0d expected %0d", e.sel, bus.RD_DATA, e.data);
        end
      end
    end
    ack_prev = bus.RD_ACK;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    for (int i = 0; i < N; i++) exp_cnt[i] = '0;
    exp_flag  = 1'b0;
    exp_vld   = 1'b0;
    exp_first = '0;
  endtask

  // Toggle the masked lines and advance the model; gap edges follow.
  task automatic toggle(input logic [N-1:0] m, input int gap);
    @(posedge CK); #1;
    bus.NR = bus.NR ^ m;
    for (int i = 0; i < N; i++)
      if (m[i] && exp_cnt[i] != 8'hFF) exp_cnt[i] = exp_cnt[i] + 8'd1;
    if (m != '0) begin
      exp_flag = 1'b1;
      if (!exp_vld) begin
        exp_vld = 1'b1;
        for (int i = 0; i < N; i++)
          if (m[i]) begin exp_first = SW'(i); break; end
      end
    end
    repeat (gap) @(posedge CK);
  endtask

  task automatic pulse_clr();
    @(posedge CK); #1 bus.CLR = 1'b1;
    @(posedge CK); #1 bus.CLR = 1'b0;
    model_clear();
  endtask

  task automatic do_read(input int sel);
    exp_t e;
    bit   got;
    e.sel  = sel;
    e.data = (sel < N) ? exp_cnt[sel] : '0;
    sb.push_back(e);
    @(posedge CK); #1;
    bus.RD_REQ = 1'b1;
    bus.RD_SEL = SW'(sel);
    got = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CK);
      if (bus.RD_ACK === 1'b1) begin got = 1; break; end
    end
    if (!got) begin
      total++; bad++;
      void'(sb.pop_back());
      $display("FAIL read_timeout sel=%0d: got RD_ACK=%b expected 1 within 10 cycles", sel, bus.RD_ACK);
    end
    @(posedge CK); #1 bus.RD_REQ = 1'b0;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CK);
      if (bus.RD_ACK === 1'b0) begin got = 1; break; end
    end
    total++;
    if (!got || bus.RD_DATA !== '0) begin
      bad++;
      $display("FAIL read_release sel=%0d: got ack=%b data=%0d expected ack=0 data=0", sel, bus.RD_ACK, bus.RD_DATA);
    end
  endtask

  task automatic test_reset();
    bit got;
    RN = 1'b0;
    bus.NR = '0; bus.CLR = 1'b0; bus.RD_REQ = 1'b0; bus.RD_SEL = '0;
    model_clear();
    repeat (2) @(posedge CK);
    #1;
    total++;
    if ({bus.FLAG, bus.FIRST_VLD, bus.FIRST, bus.RD_ACK, bus.RD_DATA} !== '0) begin
      bad++;
      $display("FAIL reset_state: got flag=%b vld=%b first=%0d ack=%b data=%0d expected all 0",
               bus.FLAG, bus.FIRST_VLD, bus.FIRST, bus.RD_ACK, bus.RD_DATA);
    end
    @(negedge CK) RN = 1'b1;
    toggle(8'h01, 3);
    @(negedge CK);
    total++;
    if (bus.FLAG !== exp_flag) begin
      bad++; $display("FAIL pre_reset_flag: got %b expected %b", bus.FLAG, exp_flag);
    end
    // Start a read, then kill it with RN while RD_ACK is high.
    sb.push_back('{sel: 0, data: exp_cnt[0]});
    @(posedge CK); #1 bus.RD_REQ = 1'b1; bus.RD_SEL = '0;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CK);
      if (bus.RD_ACK === 1'b1) begin got = 1; break; end
    end
    total++;
    if (!got) begin
      bad++; void'(sb.pop_back());
      $display("FAIL abort_read_ack: got RD_ACK=%b expected 1", bus.RD_ACK);
    end
    #2 RN = 1'b0;
    #1;
    total++;
    if ({bus.RD_ACK, bus.RD_DATA, bus.FLAG, bus.FIRST_VLD, bus.FIRST} !== '0) begin
      bad++;
      $display("FAIL reset_midread: got ack=%b data=%0d flag=%b vld=%b first=%0d expected all 0",
               bus.RD_ACK, bus.RD_DATA, bus.FLAG, bus.FIRST_VLD, bus.FIRST);
    end
    bus.RD_REQ = 1'b0;
    bus.NR = 8'hA5;
    model_clear();
    @(negedge CK) RN = 1'b1;
    repeat (8) @(posedge CK);
    @(negedge CK);
    total++;
    if (bus.FLAG !== 1'b0 || bus.FIRST_VLD !== 1'b0) begin
      bad++; $display("FAIL baseline_no_event: got flag=%b vld=%b expected 0 0", bus.FLAG, bus.FIRST_VLD);
    end
    do_read(0);
    do_read(5);
  endtask

  task automatic test_count();
    repeat (5) toggle(8'h08, 3);
    @(negedge CK);
    total++;
    if (bus.FLAG !== exp_flag || bus.FIRST_VLD !== exp_vld || bus.FIRST !== exp_first) begin
      bad++;
      $display("FAIL count_status: got flag=%b vld=%b first=%0d expected %b %b %0d",
               bus.FLAG, bus.FIRST_VLD, bus.FIRST, exp_flag, exp_vld, exp_first);
    end
    do_read(3);
    do_read(2);
  endtask

  task automatic test_simultaneous();
    pulse_clr();
    toggle(8'h42, 3);
    @(negedge CK);
    total++;
    if (bus.FIRST !== exp_first || bus.FIRST_VLD !== 1'b1 || bus.FLAG !== 1'b1) begin
      bad++;
      $display("FAIL simul_first: got first=%0d vld=%b flag=%b expected %0d 1 1",
               bus.FIRST, bus.FIRST_VLD, bus.FLAG, exp_first);
    end
    do_read(6);
    do_read(1);
  endtask

  task automatic test_saturate();
    repeat (300) toggle(8'h01, 2);
    do_read(0);
    repeat (2) toggle(8'h01, 3);
    do_read(0);
  endtask

  task automatic test_clr_same_cycle();
    pulse_clr();
    @(posedge CK); #1 bus.NR = bus.NR ^ 8'h04;
    @(posedge CK);
    @(posedge CK); #1 bus.CLR = 1'b1;
    @(posedge CK); #1 bus.CLR = 1'b0;
    model_clear();
    repeat (3) @(posedge CK);
    @(negedge CK);
    total++;
    if (bus.FLAG !== 1'b0 || bus.FIRST_VLD !== 1'b0) begin
      bad++; $display("FAIL clr_drop: got flag=%b vld=%b expected 0 0", bus.FLAG, bus.FIRST_VLD);
    end
    do_read(2);
    toggle(8'h04, 3);
    @(negedge CK);
    total++;
    if (bus.FLAG !== 1'b1 || bus.FIRST !== exp_first) begin
      bad++; $display("FAIL clr_recount: got flag=%b first=%0d expected 1 %0d", bus.FLAG, bus.FIRST, exp_first);
    end
    do_read(2);
  endtask

  task automatic test_handshake();
    logic [CW-1:0] held;
    repeat (7) toggle(8'h10, 3);
    held = exp_cnt[4];
    sb.push_back('{sel: 4, data: held});
    @(posedge CK); #1 bus.RD_REQ = 1'b1; bus.RD_SEL = 4'd4;
    @(negedge CK);
    total++;
    if (bus.RD_ACK !== 1'b0) begin
      bad++; $display("FAIL ack_latency: got RD_ACK=%b expected 0 before capture edge", bus.RD_ACK);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge CK);
      total++;
      if (bus.RD_ACK !== 1'b1 || bus.RD_DATA !== held) begin
        bad++;
        $display("FAIL ack_hold cyc=%0d: got ack=%b data=%0d expected 1 %0d", c, bus.RD_ACK, bus.RD_DATA, held);
      end
      if (c == 1) toggle_now(8'h10);
      if (c == 5) bus.RD_REQ = 1'b0;
    end
    @(negedge CK);
    total++;
    if (bus.RD_ACK !== 1'b0 || bus.RD_DATA !== '0) begin
      bad++; $display("FAIL ack_drop: got ack=%b data=%0d expected 0 0", bus.RD_ACK, bus.RD_DATA);
    end
    do_read(4);
    do_read(9);
  endtask

  task automatic toggle_now(input logic [N-1:0] m);
    bus.NR = bus.NR ^ m;
    for (int i = 0; i < N; i++)
      if (m[i] && exp_cnt[i] != 8'hFF) exp_cnt[i] = exp_cnt[i] + 8'd1;
  endtask

  task automatic test_back_to_back();
    logic [CW-1:0] held;
    do_read(4);
    do_read(2);
    do_read(0);
    // CLR while acknowledged must not disturb the captured word.
    held = exp_cnt[4];
    sb.push_back('{sel: 4, data: held});
    @(posedge CK); #1 bus.RD_REQ = 1'b1; bus.RD_SEL = 4'd4;
    repeat (2) @(negedge CK);
    bus.CLR = 1'b1;
    @(negedge CK) bus.CLR = 1'b0;
    model_clear();
    @(negedge CK);
    total++;
    if (bus.RD_ACK !== 1'b1 || bus.RD_DATA !== held || bus.FLAG !== 1'b0) begin
      bad++;
      $display("FAIL clr_during_read: got ack=%b data=%0d flag=%b expected 1 %0d 0",
               bus.RD_ACK, bus.RD_DATA, bus.FLAG, held);
    end
    bus.RD_REQ = 1'b0;
    repeat (2) @(negedge CK);
    do_read(4);
  endtask

  initial begin
    test_reset();
    test_count();
    test_simultaneous();
    test_saturate();
    test_clr_same_cycle();
    test_handshake();
    test_back_to_back();
    repeat (3) @(negedge CK);
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
